// File: rtl/stack_alu_if.sv
// Command/status bundle between the CPU control sequencer and the stack/ALU unit.
interface stack_alu_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] qtop;
  logic [WIDTH-1:0] qnext;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             carry;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output cmd_valid, cmd, din,
    input  qtop, qnext, count, empty, full, carry, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd, din,
    output qtop, qnext, count, empty, full, carry, err, err_code
  );
endinterface

// File: rtl/stack_alu_unit.sv
// Parametrised operand stack with push/pop/dup/swap/add/sub, occupancy status
// and sticky first-error reporting.
module stack_alu_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  stack_alu_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_DUP    = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_SWAP   = 3'b110;
  localparam logic [2:0] OP_CLRERR = 3'b111;

  localparam logic [1:0] CODE_OVF = 2'b01;
  localparam logic [1:0] CODE_UNF = 2'b10;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] cnt_q, cnt_n;
  logic          carry_q, carry_n;
  logic          err_q, err_n;
  logic [1:0]    code_q, code_n;

  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;

  logic [AW-1:0]    tidx, nidx, wptr;
  logic [WIDTH-1:0] top_v, nxt_v;
  logic [WIDTH:0]   sum, diff;
  logic             is_empty, is_full, lt2;
  logic             ovf, unf;

  // Top lives at count-1, next at count-2; the pointer truncation is only
  // consumed when the matching occupancy condition holds.
  assign tidx = AW'(cnt_q - CW'(1));
  assign nidx = AW'(cnt_q - CW'(2));
  assign wptr = AW'(cnt_q);

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign lt2      = (cnt_q < CW'(2));

  assign top_v = is_empty ? '0 : mem[tidx];
  assign nxt_v = lt2      ? '0 : mem[nidx];

  assign sum  = {1'b0, nxt_v} + {1'b0, top_v};
  assign diff = {1'b0, nxt_v} - {1'b0, top_v};

  always_comb begin
    cnt_n   = cnt_q;
    carry_n = carry_q;
    err_n   = err_q;
    code_n  = code_q;
    we0     = 1'b0;
    wa0     = wptr;
    wd0     = bus.din;
    we1     = 1'b0;
    wa1     = nidx;
    wd1     = top_v;
    ovf     = 1'b0;
    unf     = 1'b0;

    if (bus.cmd_valid) begin
      unique case (bus.cmd)
        OP_NOP: ;
        OP_PUSH: begin
          if (is_full) ovf = 1'b1;
          else begin
            we0   = 1'b1;
            cnt_n = cnt_q + CW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) unf = 1'b1;
          else cnt_n = cnt_q - CW'(1);
        end
        OP_DUP: begin
          if (is_empty) unf = 1'b1;
          else if (is_full) ovf = 1'b1;
          else begin
            we0   = 1'b1;
            wd0   = top_v;
            cnt_n = cnt_q + CW'(1);
          end
        end
        OP_ADD, OP_SUB: begin
          if (lt2) unf = 1'b1;
          else begin
            we0     = 1'b1;
            wa0     = nidx;
            wd0     = (bus.cmd == OP_ADD) ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
            carry_n = (bus.cmd == OP_ADD) ? sum[WIDTH] : diff[WIDTH];
            cnt_n   = cnt_q - CW'(1);
          end
        end
        OP_SWAP: begin
          if (lt2) unf = 1'b1;
          else begin
            we0 = 1'b1;
            wa0 = tidx;
            wd0 = nxt_v;
            we1 = 1'b1;
          end
        end
        OP_CLRERR: begin
          err_n  = 1'b0;
          code_n = 2'b00;
        end
        default: ;
      endcase
    end

    // First error wins until CLRERR
    if (ovf || unf) begin
      err_n = 1'b1;
      if (!err_q) code_n = unf ? CODE_UNF : CODE_OVF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      cnt_q   <= cnt_n;
      carry_q <= carry_n;
      err_q   <= err_n;
      code_q  <= code_n;
    end
  end

  // Storage is never cleared; only the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (reset && we0) mem[wa0] <= wd0;
    if (reset && we1) mem[wa1] <= wd1;
  end

  assign bus.qtop     = top_v;
  assign bus.qnext    = nxt_v;
  assign bus.count    = cnt_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.carry    = carry_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;
endmodule

// File: tb/tb_stack_alu_unit.sv
// Table-driven bench for stack_alu_unit (WIDTH=16, DEPTH=4) with an expected-result queue.
module tb_stack_alu_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         ADD = 3'd4, SUB = 3'd5, SWAP = 3'd6, CLR = 3'd7;

  typedef struct {
    int          cnt;
    logic [15:0] t;
    logic [15:0] n;
    logic        c;
    logic        e;
    logic [1:0]  code;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  op;
    logic [15:0] d;
    exp_t        x;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  vec_t tbl[$];
  exp_t sb[$];

  stack_alu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_alu_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic vld, input logic [2:0] op,
                     input logic [15:0] d, input int cnt, input logic [15:0] t,
                     input logic [15:0] n, input logic c, input logic e,
                     input logic [1:0] code);
    vec_t v;
    v.rst = rst; v.vld = vld; v.op = op; v.d = d;
    v.x.cnt = cnt; v.x.t = t; v.x.n = n; v.x.c = c; v.x.e = e; v.x.code = code;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, req);
    end
  endtask

  task automatic check(input int idx);
    exp_t x;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
      return;
    end
    x = sb.pop_front();
    cmp("count", idx, 32'(bus.count), 32'(x.cnt));
    cmp("qtop", idx, 32'(bus.qtop), 32'(x.t));
    cmp("qnext", idx, 32'(bus.qnext), 32'(x.n));
    cmp("carry", idx, 32'(bus.carry), 32'(x.c));
    cmp("err", idx, 32'(bus.err), 32'(x.e));
    cmp("err_code", idx, 32'(bus.err_code), 32'(x.code));
    cmp("empty", idx, 32'(bus.empty), 32'(x.cnt == 0));
    cmp("full", idx, 32'(bus.full), 32'(x.cnt == DEPTH));
  endtask

  task automatic step(input vec_t v, input int idx);
    reset         = ~v.rst;
    bus.cmd_valid = v.vld;
    bus.cmd       = v.op;
    bus.din       = v.d;
    sb.push_back(v.x);
    @(posedge clk);
    #1;
    check(idx);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    bus.din       = '0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    bus.din       = '0;

    // rst vld op d | cnt qtop qnext carry err code
    add(1, 0, NOP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0003, 1, 16'h0003, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0005, 2, 16'h0005, 16'h0003, 0, 0, 2'b00);
    add(0, 1, ADD,  16'h0000, 1, 16'h0008, 16'h0000, 0, 0, 2'b00);
    add(0, 1, NOP,  16'h0000, 1, 16'h0008, 16'h0000, 0, 0, 2'b00);
    // wrap-around add/sub, carry held across an error
    add(1, 0, NOP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'hFFFF, 1, 16'hFFFF, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0002, 2, 16'h0002, 16'hFFFF, 0, 0, 2'b00);
    add(0, 1, ADD,  16'h0000, 1, 16'h0001, 16'h0000, 1, 0, 2'b00);
    add(0, 1, PUSH, 16'h0003, 2, 16'h0003, 16'h0001, 1, 0, 2'b00);
    add(0, 1, SUB,  16'h0000, 1, 16'hFFFE, 16'h0000, 1, 0, 2'b00);
    add(0, 1, SWAP, 16'h0000, 1, 16'hFFFE, 16'h0000, 1, 1, 2'b10);
    // overflow
    add(1, 0, NOP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0001, 1, 16'h0001, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0002, 2, 16'h0002, 16'h0001, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0003, 3, 16'h0003, 16'h0002, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0004, 4, 16'h0004, 16'h0003, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h0009, 4, 16'h0004, 16'h0003, 0, 1, 2'b01);
    add(0, 1, DUP,  16'h0000, 4, 16'h0004, 16'h0003, 0, 1, 2'b01);
    add(0, 1, POP,  16'h0000, 3, 16'h0003, 16'h0002, 0, 1, 2'b01);
    add(0, 1, CLR,  16'h0000, 3, 16'h0003, 16'h0002, 0, 0, 2'b00);
    // underflow first, later overflow keeps code 10
    add(1, 0, NOP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, POP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2'b10);
    add(0, 1, PUSH, 16'h0007, 1, 16'h0007, 16'h0000, 0, 1, 2'b10);
    add(0, 1, PUSH, 16'h0001, 2, 16'h0001, 16'h0007, 0, 1, 2'b10);
    add(0, 1, PUSH, 16'h0002, 3, 16'h0002, 16'h0001, 0, 1, 2'b10);
    add(0, 1, PUSH, 16'h0003, 4, 16'h0003, 16'h0002, 0, 1, 2'b10);
    add(0, 1, PUSH, 16'h0005, 4, 16'h0003, 16'h0002, 0, 1, 2'b10);
    add(0, 1, CLR,  16'h0000, 4, 16'h0003, 16'h0002, 0, 0, 2'b00);
    add(0, 1, DUP,  16'h0000, 4, 16'h0003, 16'h0002, 0, 1, 2'b01);
    // swap / dup / sub to zero / ignored strobe / dup on empty
    add(1, 0, NOP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'h1234, 1, 16'h1234, 16'h0000, 0, 0, 2'b00);
    add(0, 1, PUSH, 16'hABCD, 2, 16'hABCD, 16'h1234, 0, 0, 2'b00);
    add(0, 1, SWAP, 16'h0000, 2, 16'h1234, 16'hABCD, 0, 0, 2'b00);
    add(0, 1, DUP,  16'h0000, 3, 16'h1234, 16'h1234, 0, 0, 2'b00);
    add(0, 1, SUB,  16'h0000, 2, 16'h0000, 16'hABCD, 0, 0, 2'b00);
    add(0, 0, PUSH, 16'h5555, 2, 16'h0000, 16'hABCD, 0, 0, 2'b00);
    add(0, 1, ADD,  16'h0000, 1, 16'hABCD, 16'h0000, 0, 0, 2'b00);
    add(0, 1, POP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 2'b00);
    add(0, 1, DUP,  16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2'b10);
    add(0, 1, SUB,  16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 2'b10);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Reset mid-operation with a command on the same edge, then idle strobes.
    begin
      vec_t v;
      v.rst = 1; v.vld = 0; v.op = NOP; v.d = '0;
      v.x.cnt = 0; v.x.t = '0; v.x.n = '0; v.x.c = 0; v.x.e = 0; v.x.code = 2'b00;
      step(v, 100);
      v.rst = 0; v.vld = 1; v.op = POP;
      v.x.e = 1; v.x.code = 2'b10;
      step(v, 101);
      v.op = PUSH;
      for (int k = 0; k < 3; k++) begin
        v.d = 16'(16'h00A0 + k);
        v.x.cnt = k + 1; v.x.t = v.d; v.x.n = (k == 0) ? 16'h0000 : 16'(16'h00A0 + k - 1);
        step(v, 102 + k);
      end
      v.rst = 1; v.vld = 1; v.op = PUSH; v.d = 16'h00FF;
      v.x.cnt = 0; v.x.t = '0; v.x.n = '0; v.x.c = 0; v.x.e = 0; v.x.code = 2'b00;
      step(v, 105);
      v.rst = 0; v.vld = 0; v.op = POP;
      for (int k = 0; k < 5; k++) step(v, 106 + k);
      v.vld = 1; v.op = PUSH; v.d = 16'h0042;
      v.x.cnt = 1; v.x.t = 16'h0042;
      step(v, 111);
    end

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
